// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int unsigned DIV_ITERS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring radix-2 divider core: one quotient bit per step.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_abs,
  input  logic [WIDTH-1:0] b_abs,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (load) begin
      rem_d = '0;
      quo_d = a_abs;
      dvs_d = b_abs;
    end else if (step) begin
      // Non-negative trial difference keeps the subtraction
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// MULT/MULTU/DIV/DIVU sequencer writing the HI/LO register pair.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hilo_we
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic             load, step, sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0] quo, rem, a_abs, b_abs;

  assign sgn   = (op == OP_DIV);
  assign a_abs = sgn ? abs32(a) : a;
  assign b_abs = sgn ? abs32(b) : b;

  // Extension choice makes the low 64 bits right for both signednesses
  assign a_ext = (op_q == OP_MULT) ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                                   : {{WIDTH{1'b0}}, a_q};
  assign b_ext = (op_q == OP_MULT) ? {{WIDTH{b_q[WIDTH-1]}}, b_q}
                                   : {{WIDTH{1'b0}}, b_q};
  assign prod  = a_ext * b_ext;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a_abs     (a_abs),
    .b_abs     (b_abs),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    load    = 1'b0;
    step    = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          load    = op[1];
          negq_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d  = sgn & a[WIDTH-1];
          state_d = op[1] ? S_DIV : S_MUL;
        end
        S_MUL: begin
          {hi_d, lo_d} = prod;
          state_d      = S_DONE;
        end
        S_DIV: begin
          step  = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(DIV_ITERS - 1)) state_d = S_SIGN;
        end
        S_SIGN: begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = negr_q ? -rem : rem;
            lo_d = negq_q ? -quo : quo;
          end
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) && !flush;
  assign hilo_we = done;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule
